qpsk_transmitter: RTL and testbench

Transmit-side counterpart of the receiver datapath. It reads a frame of 16-bit payload words from a data memory bank through a single read port, splits each word into 2-bit symbols, and prepends a fixed preamble. Each symbol is mapped to a QPSK constellation point and emitted as a 32-bit {I,Q} sample stream at SPS samples per symbol. It sits between the DSP/data memory and the analog front-end interface. Its 32-bit output sample format matches the receiver's 32-bit input.

---
 rtl/qpsk_transmitter.sv | 88 ++++++++
 tb/tb_qpsk_transmitter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/qpsk_transmitter.sv
// qpsk_transmitter: reads a frame of payload words, prepends an alternating preamble,
// and emits QPSK {I,Q} samples at SPS samples per symbol.
module qpsk_transmitter #(
    parameter int          SPS          = 4,
    parameter int          PREAMBLE_LEN = 16,
    parameter logic [15:0] AMP          = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] frame_len,
    output logic [15:0] read_addr,
    input  logic [15:0] read_data,
    output logic [31:0] out,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DONE} state_t;
    localparam logic [7:0]  SPS_LAST = 8'(SPS - 1);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [15:0] AMP_NEG  = ~AMP + 16'd1;
    state_t      r_state, w_next;
    logic [15:0] r_addr, r_left, r_shift;
    logic [7:0]  r_samp, r_sym;
    logic [31:0] r_out;
    logic        r_valid, r_busy, r_done;
    logic        w_active, w_sym_end, w_pre_last, w_word_end, w_load;
    logic [1:0]  w_sym;
    always_comb begin
        w_active   = r_state == PREAMBLE || r_state == PAYLOAD;
        w_sym_end  = w_active && r_samp == SPS_LAST;
        w_pre_last = r_state == PREAMBLE && w_sym_end && r_sym == PRE_LAST;
        w_word_end = r_state == PAYLOAD && w_sym_end && r_sym[2:0] == 3'd7;
        w_load     = (w_pre_last || w_word_end) && r_left != 16'd0;
        w_sym      = r_state == PREAMBLE ? {2{r_sym[0]}} : r_shift[15:14];
        w_next     = r_state;
        case (r_state)
            IDLE:     w_next = start ? PREAMBLE : IDLE;
            PREAMBLE,
            PAYLOAD:  w_next = (w_pre_last || w_word_end) ? (w_load ? PAYLOAD : DONE) : r_state;
            default:  w_next = IDLE;
        endcase
    end
    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= 16'd0;
            r_left  <= 16'd0;
            r_shift <= 16'd0;
            r_samp  <= 8'd0;
            r_sym   <= 8'd0;
            r_out   <= 32'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_active;
            r_busy  <= r_state != IDLE;
            r_done  <= r_state == DONE;
            r_out   <= w_active ? {w_sym[1] ? AMP_NEG : AMP, w_sym[0] ? AMP_NEG : AMP} : 32'd0;
            if (r_state == IDLE && start) begin
                r_addr <= base_addr;
                r_left <= frame_len;
                r_samp <= 8'd0;
                r_sym  <= 8'd0;
            end else if (w_active) begin
                r_samp <= w_sym_end ? 8'd0 : r_samp + 8'd1;
                if (w_sym_end) begin
                    r_sym   <= (w_pre_last || w_word_end) ? 8'd0 : r_sym + 8'd1;
                    r_shift <= w_load ? read_data : {r_shift[13:0], 2'b00};
                end
                if (w_load) begin
                    r_addr <= r_addr + 16'd1;
                    r_left <= r_left - 16'd1;
                end
            end
        end
    end
    assign read_addr = r_addr;
    assign out       = r_out;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_qpsk_transmitter.sv
// tb_qpsk_transmitter: directed frames against hand-derived sample sequences.
module tb_qpsk_transmitter;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] base_addr = 16'd0, frame_len = 16'd0;
    logic [15:0] read_addr, read_data;
    logic [31:0] out;
    logic        out_valid, busy, done;
    logic [15:0] mem [0:65535];
    logic [15:0] wq[$];
    logic [31:0] samp[$], exp_q[$];
    logic [15:0] addr_at_done;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          first_v, last_v, n_done, s_cyc, lv;

    qpsk_transmitter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .frame_len(frame_len),
        .read_addr(read_addr), .read_data(read_data), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign read_data = mem[read_addr];

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] sym_val(input logic [1:0] d);
        return {d[1] ? 16'hE000 : 16'h2000, d[0] ? 16'hE000 : 16'h2000};
    endfunction

    task automatic build_exp();
        exp_q.delete();
        for (int p = 0; p < 16; p++)
            for (int k = 0; k < 4; k++) exp_q.push_back(sym_val(p[0] ? 2'b11 : 2'b00));
        foreach (wq[w])
            for (int s = 0; s < 8; s++)
                for (int k = 0; k < 4; k++) exp_q.push_back(sym_val(wq[w][15-2*s -: 2]));
    endtask

    task automatic cmp_frame(input string tag);
        int nbad = 0;
        build_exp();
        check({tag, "_len"}, samp.size(), exp_q.size());
        for (int i = 0; i < samp.size() && i < exp_q.size(); i++)
            if (samp[i] !== exp_q[i]) nbad++;
        check({tag, "_bad_samples"}, nbad, 0);
    endtask

    task automatic start_frame(input logic [15:0] b, input logic [15:0] l);
        @(negedge clk);
        base_addr = b;
        frame_len = l;
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("no_early_valid", out_valid, 0);
    endtask

    task automatic collect(input bit inj, input bit b2b, input logic [15:0] nb, input logic [15:0] nl);
        int done_c = -1;
        samp.delete();
        n_done = 0;
        first_v = -1;
        last_v = -1;
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            @(negedge clk);
            if (inj && i == 70) begin
                check("busy_mid", busy, 1);
                start = 1'b1;
                base_addr = 16'h0040;
                frame_len = 16'd3;
            end
            if (inj && i == 71) start = 1'b0;
            if (out_valid) begin
                samp.push_back(out);
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (done) begin
                n_done++;
                done_c = cyc;
                addr_at_done = read_addr;
                if (b2b) begin
                    start = 1'b1;
                    base_addr = nb;
                    frame_len = nl;
                end
            end
        end
        check("done_seen", n_done, 1);
        check("done_after_last", done_c - last_v, 1);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_low_after", busy, 0);
    endtask

    initial begin
        bit bad;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_hold_valid", out_valid, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", read_addr, 0);

        wq.delete();
        start_frame(16'h0100, 16'd0);
        collect(0, 0, 16'd0, 16'd0);
        check("pre_latency", first_v - s_cyc, 2);
        cmp_frame("pre");
        check("pre_s0", samp[0], 32'h2000_2000);
        check("pre_s4", samp[4], 32'hE000_E000);
        check("pre_addr", addr_at_done, 16'h0100);

        mem[16'h0010] = 16'h1B1B;
        wq = '{16'h1B1B};
        start_frame(16'h0010, 16'd1);
        collect(0, 0, 16'd0, 16'd0);
        cmp_frame("one");
        check("one_s68", samp[68], 32'h2000_E000);
        check("one_s72", samp[72], 32'hE000_2000);
        check("one_s95", samp[95], 32'hE000_E000);
        check("one_addr", addr_at_done, 16'h0011);

        mem[16'hFFFF] = 16'h0000;
        mem[16'h0000] = 16'hFFFF;
        wq = '{16'h0000, 16'hFFFF};
        start_frame(16'hFFFF, 16'd2);
        collect(0, 0, 16'd0, 16'd0);
        cmp_frame("wrap");
        check("wrap_s64", samp[64], 32'h2000_2000);
        check("wrap_s96", samp[96], 32'hE000_E000);
        check("wrap_addr", addr_at_done, 16'h0001);

        mem[16'h0020] = 16'hA5C3;
        mem[16'h0040] = 16'h5555;
        wq = '{16'hA5C3};
        start_frame(16'h0020, 16'd1);
        collect(1, 1, 16'h0010, 16'd1);
        cmp_frame("busy");
        check("busy_addr", addr_at_done, 16'h0021);
        lv = last_v;
        wq = '{16'h1B1B};
        collect(0, 0, 16'd0, 16'd0);
        cmp_frame("b2b");
        check("b2b_gap", first_v - lv, 3);
        check("b2b_addr", addr_at_done, 16'h0011);

        mem[16'h0030] = 16'h1234;
        mem[16'h0031] = 16'h5678;
        start_frame(16'h0030, 16'd4);
        repeat (100) @(negedge clk);
        check("mid_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", read_addr, 0);
        bad = 1'b0;
        repeat (3) @(negedge clk) if (done) bad = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk) if (done || busy || out_valid) bad = 1'b1;
        check("arst_quiet", bad, 0);

        mem[16'h0050] = 16'h0F0F;
        mem[16'h0051] = 16'h3C96;
        wq = '{16'h0F0F, 16'h3C96};
        start_frame(16'h0050, 16'd2);
        collect(0, 0, 16'd0, 16'd0);
        cmp_frame("after_rst");
        check("after_rst_addr", addr_at_done, 16'h0052);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
